// File: rtl/hub75_pkg.sv
// Shared types, default geometry and helper functions for the HUB75 BCM scan driver.
package hub75_pkg;

   // Scan FSM phases, in the order a plane walks through them.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_BLANK,
      ST_LATCH,
      ST_DISPLAY
   } scan_state_t;

   // Default panel geometry (64x32 panel, 4-bit colour).
   localparam int DEF_PANEL_W = 64;
   localparam int DEF_ADDR_W  = 5;
   localparam int DEF_BPC     = 4;
   localparam int DEF_CLK_DIV = 2;
   localparam int DEF_BASE_ON = 16;

   // Column counter width for a given shift length.
   function automatic int col_w(input int panel_w);
      return $clog2(panel_w);
   endfunction

   // One column slot covers a full low+high period of the panel shift clock.
   function automatic int slot_len(input int clk_div);
      return 2 * clk_div;
   endfunction

   // Display counter width: the largest plane time BASE_ON<<(BPC-1) fits without overflow.
   function automatic int disp_w(input int bpc, input int base_on);
      return bpc - 1 + $clog2(base_on) + 1;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Display time of bit-plane p: binary weighting of the plane.
   function automatic int unsigned plane_time(input int unsigned base_on, input int unsigned p);
      return base_on << p;
   endfunction

   localparam int COL_W    = col_w(DEF_PANEL_W);
   localparam int SLOT_LEN = slot_len(DEF_CLK_DIV);
   localparam int DISP_W   = disp_w(DEF_BPC, DEF_BASE_ON);

endpackage

// File: rtl/hub75_bcm_timer.sv
// Loadable down-counter timing the BLANK, LATCH and DISPLAY phases.
// Load N-1 to obtain a phase of N cycles: done is high in the last one.
module hub75_bcm_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] count;

   // Count down from the loaded value and park at zero.
   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/hub75_bcm_scan_driver.sv
// HUB75 panel scan driver with binary-coded modulation greyscale.
// Each row is shown as BPC bit-planes: shift the plane's bits, blank, latch,
// then light the row for BASE_ON<<p cycles.
module hub75_bcm_scan_driver
   import hub75_pkg::*;
#(
   parameter int PANEL_W   = 64,
   parameter int ADDR_W    = 5,
   parameter int BPC       = 4,
   parameter int CLK_DIV   = 2,
   parameter int BLANK_CYC = 4,
   parameter int LATCH_CYC = 2,
   parameter int BASE_ON   = 16
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               enable,
   output logic                               fb_rd_en,
   output logic [ADDR_W+$clog2(PANEL_W)-1:0]  fb_addr,
   input  logic [3*BPC-1:0]                   fb_data0,
   input  logic [3*BPC-1:0]                   fb_data1,
   output logic                               r0,
   output logic                               g0,
   output logic                               b0,
   output logic                               r1,
   output logic                               g1,
   output logic                               b1,
   output logic [ADDR_W-1:0]                  addr,
   output logic                               clk_out,
   output logic                               latch,
   output logic                               oe,
   output logic                               frame_start
);

   localparam int CW = col_w(PANEL_W);
   localparam int SL = slot_len(CLK_DIV);
   localparam int SW = $clog2(SL);
   localparam int PW = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int DW = disp_w(BPC, BASE_ON);
   localparam int TW = max_int(DW, max_int($clog2(BLANK_CYC + 1), $clog2(LATCH_CYC + 1)));

   scan_state_t        state, state_nxt;
   logic [SW-1:0]      slot_cyc;
   logic [CW-1:0]      col;
   logic [ADDR_W-1:0]  row;
   logic [PW-1:0]      plane;

   logic               shift_last;
   logic               plane_end;
   logic               tmr_load;
   logic [TW-1:0]      tmr_val;
   logic               tmr_done;

   // Per-channel views of the two pixels, so the plane bit is a plain index.
   logic [BPC-1:0]     red0, grn0, blu0, red1, grn1, blu1;

   assign red0 = fb_data0[3*BPC-1:2*BPC];
   assign grn0 = fb_data0[2*BPC-1:BPC];
   assign blu0 = fb_data0[BPC-1:0];
   assign red1 = fb_data1[3*BPC-1:2*BPC];
   assign grn1 = fb_data1[2*BPC-1:BPC];
   assign blu1 = fb_data1[BPC-1:0];

   assign shift_last = (state == ST_SHIFT) && (slot_cyc == SW'(SL - 1)) && (col == CW'(PANEL_W - 1));
   assign plane_end  = (state == ST_DISPLAY) && tmr_done;

   hub75_bcm_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; the timer is loaded on the last cycle of the preceding phase.
   // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      case (state)
         ST_IDLE: begin
            if (enable) state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (shift_last) begin
               state_nxt = ST_BLANK;
               tmr_load  = 1'b1;
               tmr_val   = TW'(BLANK_CYC - 1);
            end
         end
         ST_BLANK: begin
            if (tmr_done) begin
               state_nxt = ST_LATCH;
               tmr_load  = 1'b1;
               tmr_val   = TW'(LATCH_CYC - 1);
            end
         end
         ST_LATCH: begin
            if (tmr_done) begin
               state_nxt = ST_DISPLAY;
               tmr_load  = 1'b1;
               tmr_val   = TW'(plane_time(BASE_ON, 32'(plane)) - 1);
            end
         end
         ST_DISPLAY: begin
            if (tmr_done) state_nxt = enable ? ST_SHIFT : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Column and slot-cycle counters; both wrap back to zero at the end of SHIFT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_cyc <= '0;
         col      <= '0;
      end else if (state == ST_SHIFT) begin
         if (slot_cyc == SW'(SL - 1)) begin
            slot_cyc <= '0;
            col      <= col + 1'b1;
         end else begin
            slot_cyc <= slot_cyc + 1'b1;
         end
      end
   end

   // Advance plane, and row after the last plane, when a display phase finishes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         plane <= '0;
         row   <= '0;
      end else if (plane_end) begin
         if (plane == PW'(BPC - 1)) begin
            plane <= '0;
            row   <= row + 1'b1;
         end else begin
            plane <= plane + 1'b1;
         end
      end
   end

   // Panel row select follows the shifted row once the row is blanked.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr <= '0;
      end else if (shift_last) begin
         addr <= row;
      end
   end

   // Capture the current plane's bit of both pixels while clk_out is still low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {r0, g0, b0, r1, g1, b1} <= '0;
      end else if ((state == ST_SHIFT) && (slot_cyc == SW'(1))) begin
         r0 <= red0[plane];
         g0 <= grn0[plane];
         b0 <= blu0[plane];
         r1 <= red1[plane];
         g1 <= grn1[plane];
         b1 <= blu1[plane];
      end
   end

   assign fb_rd_en    = (state == ST_SHIFT) && (slot_cyc == '0);
   assign fb_addr     = {row, col};
   assign clk_out     = (state == ST_SHIFT) && (slot_cyc >= SW'(CLK_DIV));
   assign latch       = (state == ST_LATCH);
   assign oe          = (state != ST_DISPLAY);
   assign frame_start = fb_rd_en && (col == '0) && (row == '0) && (plane == '0);

endmodule
